i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (slave) block: the responder end of the bus driven by the `top` I2C controller.
- Runs on the system clock. Oversamples SCL/SDA, detects START/STOP, matches a fixed 7-bit address, ACKs, and receives or transmits bytes.
- Received bytes go to the fabric with a valid pulse; read bytes come from a fabric-supplied register.
- Used as the on-chip bus model in system benches and as a loopback target on the board.

Parameters:
- ADDR, 7'h50, 7-bit target address the block responds to.
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (minimum 2).
- HOLD_CYCLES, 25, clk cycles after SCL falling edge before SDA drive changes (data hold time).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-low reset.
- scl_i  in  1  SCL as seen on the bus pad.
- sda_i  in  1  SDA as seen on the bus pad.
- sda_t  out  1  SDA tristate: 1 = release (pulled up), 0 = drive low.
- tx_data  in  8  byte returned on a read; sampled when each read byte begins.
- tx_load  out  1  1-cycle pulse when tx_data is sampled (fabric may then advance).
- rx_data  out  8  last byte written by the controller.
- rx_valid  out  1  1-cycle pulse when rx_data updates.
- busy  out  1  high between a detected START and the following STOP.
- addressed  out  1  high from a matching-address ACK until STOP or repeated START.

Behaviour:
- Reset (rst==0 at posedge clk): all outputs return to their reset values.
  - sda_t=1, rx_data=0, rx_valid=0, tx_load=0, busy=0, addressed=0.
  - State goes to IDLE; the bit counter is cleared.
  - Synchronizer flops preset to 1.
- All bus logic uses the synchronized signals scl_s/sda_s and their previous-cycle values.
- Edge and condition detection, evaluated every clk:
  - SCL rise: scl_s & ~scl_p. SCL fall: ~scl_s & scl_p.
  - START: scl_s & scl_p & sda_p & ~sda_s.
  - STOP: scl_s & scl_p & ~sda_p & sda_s.
- Priority: START/STOP override any state, including mid-byte and mid-ACK.
  - START → ADDR, busy=1, addressed=0, bit counter=0, sda_t=1.
  - STOP → IDLE, busy=0, addressed=0, sda_t=1.
- Bits are sampled on SCL rise, MSB first, into an 8-bit shift register.
- All SDA drive changes are scheduled HOLD_CYCLES clk after SCL fall by a shared hold counter.
  - A new SCL fall restarts the counter.
- States:
  - IDLE: sda_t=1; waits for START.
  - ADDR: shifts in 8 bits (7-bit address + R/W) on the 8th SCL rise.
    - Match: latch R/W → ADDR_ACK.
    - No match → IDLE (ignore bus until the next START; busy stays 1).
  - ADDR_ACK: on the hold point after the 8th SCL fall, sda_t=0 and addressed=1.
    - Release on the hold point after the 9th SCL fall.
    - R/W=0 → WRITE. R/W=1 → READ, with tx_data loaded (tx_load pulse) at the 9th SCL fall.
  - WRITE: shifts 8 bits. On the 8th SCL rise, rx_data=shift and rx_valid pulses → WRITE_ACK.
  - WRITE_ACK: drive ACK as in ADDR_ACK → WRITE. The controller ends the transfer with STOP or repeated START.
  - READ: drive bit 7-i at each hold point (0 → sda_t=0, 1 → sda_t=1).
    - Release SDA at the hold point after the 8th SCL fall → READ_ACK.
  - READ_ACK: sample SDA on the 9th SCL rise.
    - 0 (ACK): load next tx_data at the 9th SCL fall (tx_load) → READ.
    - 1 (NACK): → IDLE with sda_t=1; busy stays 1 until STOP.
- Latency: rx_valid is 1 clk after the synchronized 8th SCL rise of the data byte.
- Never drives SDA while scl_s=1, except holding a bit or ACK already on the bus.
- Reset while a transfer is in progress: SDA is released in the same cycle. The block re-arms only on a fresh START.
- Clock stretching is not supported: scl_i is input-only.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_tgt_state_t (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK).
  - Constants I2C_RW_READ=1 and I2C_ACK=0.
- Sub-module i2c_bus_sync: SYNC_STAGES synchronizer plus edge/START/STOP detector, outputs scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det. It is reusable by the controller.

Test Plan:
- Write 0x50 (0xA0) then 0xA5, STOP → ACK low on both 9th clocks; rx_data=0xA5 with exactly one rx_valid pulse; busy falls at STOP.
- Write to address 0x51 (0xA2) then 0xA5 → sda_t stays 1 throughout; no rx_valid; addressed never asserts.
- Read 0x50 (0xA1) with tx_data=0x3C, controller NACKs → SDA bits 0,0,1,1,1,1,0,0 sampled on SCL rises; one tx_load; SDA released; back to IDLE.
- Two-byte read (tx_data 0x3C then 0xC3, ACK then NACK) → two tx_load pulses, correct bytes, no SDA drive after NACK.
- Write 0x11 then repeated START with read → rx_data=0x11; addressed drops at repeated START and reasserts at the read ACK; read data correct.
- rst=0 for one cycle during data bit 4 of a read → sda_t=1 the next cycle; no response until the next START; the next full write transfer completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus front end.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6
  } i2c_tgt_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_p_q;
  logic                   sda_p_q;

  // Presetting to the idle bus level keeps reset from looking like an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_p_q    <= scl_sync_q[SYNC_STAGES-1];
      sda_p_q    <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p_q;
  assign scl_fall  = ~scl_s & scl_p_q;
  assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, ACK generation, byte receive and transmit.
// tx_load/rx_valid are single-cycle strobes with no back-pressure: the fabric must accept them.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         HOLD_CYCLES = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addressed,
  output logic [2:0] dbg_state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           phase_q, phase_d;
  logic           rw_q, rw_d;
  logic           sda_t_q, sda_t_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           tx_load_q, tx_load_d;
  logic           busy_q, busy_d;
  logic           addressed_q, addressed_d;
  logic           hold_act_q, hold_act_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           hold_pt;

  // SDA only ever changes here, HOLD_CYCLES after an SCL fall and never with SCL high.
  assign hold_pt = hold_act_q && (hold_cnt_q == HW'(HOLD_CYCLES - 1)) && !scl_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    sda_t_d     = sda_t_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    hold_act_d  = hold_act_q;
    hold_cnt_d  = hold_cnt_q;

    // A rise cancels a pending hold point so entering an ACK state never acts on a stale fall.
    if (scl_fall) begin
      hold_act_d = 1'b1;
      hold_cnt_d = '0;
    end else if (scl_rise || hold_pt) begin
      hold_act_d = 1'b0;
    end else if (hold_act_q) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end

    if (start_det) begin
      state_d     = ST_ADDR;
      cnt_d       = '0;
      phase_d     = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      sda_t_d     = 1'b1;
      hold_act_d  = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_t_d     = 1'b1;
      hold_act_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (shift_q[6:0] == ADDR) begin
              rw_d    = sda_s;
              phase_d = 1'b0;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK, ST_WRITE_ACK: begin
          if (!phase_q) begin
            if (hold_pt) begin
              sda_t_d = I2C_ACK;
              phase_d = 1'b1;
              if (state_q == ST_ADDR_ACK) addressed_d = 1'b1;
            end
          end else if (scl_fall) begin
            cnt_d = '0;
            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
              shift_d   = tx_data;
              tx_load_d = 1'b1;
              state_d   = ST_READ;
            end else begin
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (hold_pt) sda_t_d = 1'b1;
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = ST_WRITE_ACK;
            end
          end
        end
        ST_READ: begin
          if (scl_fall) cnt_d = cnt_q + 4'd1;
          if (hold_pt) begin
            if (cnt_q == 4'd8) begin
              sda_t_d = 1'b1;
              phase_d = 1'b0;
              state_d = ST_READ_ACK;
            end else begin
              sda_t_d = shift_q[3'd7 - cnt_q[2:0]];
            end
          end
        end
        ST_READ_ACK: begin
          if (!phase_q) begin
            if (scl_rise) begin
              if (sda_s != I2C_ACK) state_d = ST_IDLE;
              else                  phase_d = 1'b1;
            end
          end else if (scl_fall) begin
            shift_d   = tx_data;
            tx_load_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_READ;
          end
        end
        default: sda_t_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      phase_q     <= 1'b0;
      rw_q        <= 1'b0;
      sda_t_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      hold_act_q  <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      rw_q        <= rw_d;
      sda_t_q     <= sda_t_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      hold_act_q  <= hold_act_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign sda_t     = sda_t_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_load   = tx_load_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, bus monitor and transaction-level reference model.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 35;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_c = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_t, tx_load, rx_valid, busy, addressed;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;
  wire        sda_bus = sda_c & sda_t;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_rx_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic       ack_q[$];

  int   n_tx_load = 0;
  int   n_addr_rise = 0;
  int   n_viol = 0;
  logic saw_drive = 1'b0;
  logic saw_addressed = 1'b0;
  logic scl_prev = 1'b1;
  logic sda_t_prev = 1'b1;
  logic addr_prev = 1'b0;

  i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2), .HOLD_CYCLES(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_t     (sda_t),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .addressed (addressed),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Bus monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) got_rx_q.push_back(rx_data);
    if (tx_load) n_tx_load++;
    if (addressed) saw_addressed = 1'b1;
    if (addressed && !addr_prev) n_addr_rise++;
    if (!sda_t) saw_drive = 1'b1;
    if (rst && scl && scl_prev && sda_t !== sda_t_prev) n_viol++;
    scl_prev   = scl;
    sda_t_prev = sda_t;
    addr_prev  = addressed;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_rx_q.delete();
    n_tx_load     = 0;
    n_addr_rise   = 0;
    saw_drive     = 1'b0;
    saw_addressed = 1'b0;
  endtask

  task automatic bus_start();
    sda_c = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_c = 1'b0; wait_clk(Q);
    scl   = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q); sda_c = 1'b0;
    wait_clk(Q); scl   = 1'b1;
    wait_clk(Q); sda_c = 1'b1;
    wait_clk(Q);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    wait_clk(Q); sda_c = b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); r = sda_bus;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      b[i] = r;
    end
    bus_bit(nack, r);
  endtask

  // Writes send wr_q; reads ACK every byte but the last and supply tx_q as the fabric.
  task automatic xfer(input logic [6:0] a, input logic rw, input int n, input logic with_stop);
    logic       ack;
    logic [7:0] b;
    ack_q.delete();
    rd_q.delete();
    if (tx_q.size() > 0) tx_data = tx_q[0];
    bus_start();
    send_byte({a, rw}, ack);
    ack_q.push_back(ack);
    if (!rw || ack_q[0] == 1'b0) begin
      for (int i = 0; i < n; i++) begin
        if (rw) begin
          wait_clk(8);
          tx_data = (i + 1 < tx_q.size()) ? tx_q[i+1] : 8'h00;
          recv_byte(i == n - 1, b);
          rd_q.push_back(b);
        end else begin
          send_byte(wr_q[i], ack);
          ack_q.push_back(ack);
        end
      end
    end
    if (with_stop) bus_stop();
  endtask

  task automatic test_reset();
    rst = 1'b0; scl = 1'b1; sda_c = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(5);
    n_checks++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL reset_sda_t: got %b want 1", sda_t); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load: got %b want 0", tx_load); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL reset_addressed: got %b want 0", addressed); end
    n_checks++; if (dbg_state !== 3'(ST_IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, 3'(ST_IDLE)); end
  endtask

  task automatic test_write();
    clear_mon();
    wr_q = '{8'hA5};
    exp_q = '{8'hA5};
    xfer(7'h50, 1'b0, 1, 1'b0);
    n_checks++; if (ack_q[0] !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", ack_q[0]); end
    n_checks++; if (ack_q[1] !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack: got %b want 0", ack_q[1]); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_before_stop: got %b want 1", busy); end
    n_checks++; if (addressed !== 1'b1) begin n_fail++; $display("FAIL wr_addressed: got %b want 1", addressed); end
    bus_stop();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
    n_checks++; if (got_rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wr_rx_count: got %0d want %0d", got_rx_q.size(), exp_q.size()); end
    n_checks++; if (rx_data !== exp_q[0]) begin n_fail++; $display("FAIL wr_rx_data: got %h want %h", rx_data, exp_q[0]); end
  endtask

  task automatic test_wrong_addr();
    clear_mon();
    wr_q = '{8'hA5};
    xfer(7'h51, 1'b0, 1, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL na_busy_held: got %b want 1", busy); end
    bus_stop();
    n_checks++; if (ack_q[0] !== 1'b1) begin n_fail++; $display("FAIL na_addr_ack: got %b want 1", ack_q[0]); end
    n_checks++; if (ack_q[1] !== 1'b1) begin n_fail++; $display("FAIL na_data_ack: got %b want 1", ack_q[1]); end
    n_checks++; if (saw_drive !== 1'b0) begin n_fail++; $display("FAIL na_sda_driven: got %b want 0", saw_drive); end
    n_checks++; if (got_rx_q.size() != 0) begin n_fail++; $display("FAIL na_rx_count: got %0d want 0", got_rx_q.size()); end
    n_checks++; if (saw_addressed !== 1'b0) begin n_fail++; $display("FAIL na_addressed: got %b want 0", saw_addressed); end
  endtask

  task automatic test_read_single();
    clear_mon();
    tx_q = '{8'h3C};
    xfer(7'h50, 1'b1, 1, 1'b0);
    saw_drive = 1'b0;
    bus_stop();
    n_checks++; if (ack_q[0] !== 1'b0) begin n_fail++; $display("FAIL rd1_addr_ack: got %b want 0", ack_q[0]); end
    n_checks++; if (rd_q[0] !== 8'h3C) begin n_fail++; $display("FAIL rd1_data: got %h want 3c", rd_q[0]); end
    n_checks++; if (n_tx_load != 1) begin n_fail++; $display("FAIL rd1_tx_load: got %0d want 1", n_tx_load); end
    n_checks++; if (saw_drive !== 1'b0 || sda_t !== 1'b1) begin n_fail++; $display("FAIL rd1_release: got drive=%b sda_t=%b want 0/1", saw_drive, sda_t); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd1_busy: got %b want 0", busy); end
  endtask

  task automatic test_read_two();
    clear_mon();
    tx_q = '{8'h3C, 8'hC3};
    xfer(7'h50, 1'b1, 2, 1'b0);
    saw_drive = 1'b0;
    bus_stop();
    n_checks++; if (rd_q[0] !== 8'h3C) begin n_fail++; $display("FAIL rd2_byte0: got %h want 3c", rd_q[0]); end
    n_checks++; if (rd_q[1] !== 8'hC3) begin n_fail++; $display("FAIL rd2_byte1: got %h want c3", rd_q[1]); end
    n_checks++; if (n_tx_load != 2) begin n_fail++; $display("FAIL rd2_tx_load: got %0d want 2", n_tx_load); end
    n_checks++; if (saw_drive !== 1'b0) begin n_fail++; $display("FAIL rd2_drive_after_nack: got %b want 0", saw_drive); end
  endtask

  task automatic test_repeated_start();
    clear_mon();
    wr_q = '{8'h11};
    xfer(7'h50, 1'b0, 1, 1'b0);
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL rs_rx_data: got %h want 11", rx_data); end
    tx_q = '{8'h96};
    xfer(7'h50, 1'b1, 1, 1'b0);
    n_checks++; if (rd_q[0] !== 8'h96) begin n_fail++; $display("FAIL rs_read_data: got %h want 96", rd_q[0]); end
    n_checks++; if (n_addr_rise != 2) begin n_fail++; $display("FAIL rs_addressed_rises: got %0d want 2", n_addr_rise); end
    n_checks++; if (addressed !== 1'b1) begin n_fail++; $display("FAIL rs_addressed_held: got %b want 1", addressed); end
    bus_stop();
    n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL rs_addressed_stop: got %b want 0", addressed); end
  endtask

  task automatic test_reset_midread();
    logic       r;
    logic [7:0] b;
    clear_mon();
    tx_data = 8'h00;
    bus_start();
    send_byte(8'hA1, r);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
    wait_clk(2 * Q);
    n_checks++; if (sda_t !== 1'b0) begin n_fail++; $display("FAIL rst_pre_drive: got %b want 0", sda_t); end
    rst = 1'b0;
    wait_clk(1);
    rst = 1'b1;
    n_checks++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL rst_release: got %b want 1", sda_t); end
    clear_mon();
    scl = 1'b1; wait_clk(2 * Q); scl = 1'b0;
    for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
    bus_stop();
    n_checks++; if (saw_drive !== 1'b0 || n_tx_load != 0) begin n_fail++; $display("FAIL rst_silent: got drive=%b loads=%0d want 0/0", saw_drive, n_tx_load); end
    wr_q = '{8'h77};
    xfer(7'h50, 1'b0, 1, 1'b1);
    b = (got_rx_q.size() > 0) ? got_rx_q[0] : 8'hxx;
    n_checks++; if (ack_q[0] !== 1'b0 || ack_q[1] !== 1'b0) begin n_fail++; $display("FAIL rst_rearm_acks: got %b%b want 00", ack_q[0], ack_q[1]); end
    n_checks++; if (got_rx_q.size() != 1 || b !== 8'h77) begin n_fail++; $display("FAIL rst_rearm_rx: got n=%0d data=%h want 1/77", got_rx_q.size(), b); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      logic [6:0] a;
      logic       rw;
      logic       m;
      int         n;
      a  = ($urandom_range(0, 2) != 0) ? 7'h50 : 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      m  = (a == 7'h50);
      wr_q.delete(); tx_q.delete(); exp_q.delete();
      for (int i = 0; i < n; i++) begin
        wr_q.push_back(8'($urandom));
        tx_q.push_back(8'($urandom));
      end
      if (m && !rw) exp_q = wr_q;
      clear_mon();
      xfer(a, rw, n, 1'b1);
      n_checks++; if (ack_q[0] !== !m) begin n_fail++; $display("FAIL rnd%0d_addr_ack: got %b want %b", t, ack_q[0], !m); end
      n_checks++; if (n_tx_load != ((m && rw) ? n : 0)) begin n_fail++; $display("FAIL rnd%0d_tx_load: got %0d want %0d", t, n_tx_load, (m && rw) ? n : 0); end
      n_checks++; if (got_rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_rx_count: got %0d want %0d", t, got_rx_q.size(), exp_q.size()); end
      for (int i = 0; i < n; i++) begin
        if (!rw) begin
          n_checks++; if (ack_q[i+1] !== !m) begin n_fail++; $display("FAIL rnd%0d_data_ack%0d: got %b want %b", t, i, ack_q[i+1], !m); end
        end else if (m) begin
          n_checks++; if (rd_q[i] !== tx_q[i]) begin n_fail++; $display("FAIL rnd%0d_rd%0d: got %h want %h", t, i, rd_q[i], tx_q[i]); end
        end
      end
      for (int i = 0; i < exp_q.size() && i < got_rx_q.size(); i++) begin
        n_checks++; if (got_rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_rx%0d: got %h want %h", t, i, got_rx_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read_single();
    test_read_two();
    test_repeated_start();
    test_reset_midread();
    test_random();
    n_checks++; if (n_viol != 0) begin n_fail++; $display("FAIL sda_change_scl_high: got %0d want 0", n_viol); end
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
